uart_tx_param: RTL and testbench

Parametrised UART transmitter, successor to the fixed 8N1 transmitter in the peripheral set.
- Data width and oversampling ratio are generic.
- Parity mode and stop-bit count are selected per frame; a line-break output mode is added.
- Sits between the UART TX FIFO and the pin, driven by the shared baud-tick generator (sTick).
- Data is latched once at acceptance, so din may change during the frame.

---
 rtl/uart_tx_param.sv | 158 +++++++++++++++
 tb/tb_uart_tx_param.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start, DATA_BITS data (LSB first), optional parity, 1 or 2 stops.
// States: IDLE idle/break line | START start bit | DATA data bits | PARITY parity bit | STOP stop bit(s)
module uart_tx_param #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int TICK_W     = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sTick,
  input  logic                 txStart,
  input  logic [DATA_BITS-1:0] din,
  input  logic [1:0]           parityMode,
  input  logic                 stopTwo,
  input  logic                 txBreak,
  output logic                 tx,
  output logic                 txRdTick,
  output logic                 txBusy,
  output logic                 txDone
);

  localparam int BIT_W = $clog2(DATA_BITS);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               state_q, state_d;
  logic [TICK_W-1:0]    tick_q, tick_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_en_q, par_en_d;
  logic                 par_q, par_d;
  logic                 stop_two_q, stop_two_d;
  logic                 tx_q, tx_d;
  logic                 busy_q;
  logic                 done_q, done_d;
  logic                 tick_last, stop_last;

  assign tick_last = (tick_q == TICK_W'(OVERSAMPLE - 1));
  assign stop_last = (tick_q == (stop_two_q ? TICK_W'(2 * OVERSAMPLE - 1)
                                            : TICK_W'(OVERSAMPLE - 1)));

  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    par_en_d   = par_en_q;
    par_d      = par_q;
    stop_two_d = stop_two_q;
    done_d     = 1'b0;
    txRdTick   = 1'b0;
    tx_d       = 1'b1;

    case (state_q)
      S_IDLE: begin
        // reset gates the strobe so the FIFO is never popped while held in reset
        if (txStart && !txBreak && reset) begin
          txRdTick   = 1'b1;
          shift_d    = din;
          par_en_d   = (parityMode == 2'b01) || (parityMode == 2'b10);
          par_d      = (parityMode == 2'b10) ? ~(^din) : ^din;
          stop_two_d = stopTwo;
          tick_d     = '0;
          state_d    = S_START;
        end
      end
      S_START: begin
        if (sTick) begin
          if (tick_last) begin
            tick_d  = '0;
            bit_d   = '0;
            state_d = S_DATA;
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
      end
      S_DATA: begin
        if (sTick) begin
          if (tick_last) begin
            tick_d  = '0;
            shift_d = shift_q >> 1;
            if (bit_q == BIT_W'(DATA_BITS - 1)) begin
              state_d = par_en_q ? S_PARITY : S_STOP;
            end else begin
              bit_d = bit_q + BIT_W'(1);
            end
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (sTick) begin
          if (tick_last) begin
            tick_d  = '0;
            state_d = S_STOP;
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
      end
      S_STOP: begin
        if (sTick) begin
          if (stop_last) begin
            tick_d  = '0;
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // line level follows the state being entered so tx is aligned with the state register
    case (state_d)
      S_IDLE:   tx_d = ~txBreak;
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_q;
      S_STOP:   tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      tick_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      par_en_q   <= 1'b0;
      par_q      <= 1'b0;
      stop_two_q <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      par_en_q   <= par_en_d;
      par_q      <= par_d;
      stop_two_q <= stop_two_d;
      tx_q       <= tx_d;
      busy_q     <= (state_d != S_IDLE);
      done_q     <= done_d;
    end
  end

  assign tx     = tx_q;
  assign txBusy = busy_q;
  assign txDone = done_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Scoreboard bench for uart_tx_param: stimulus pushes expected frames, a monitor
// samples tx on every sTick between txRdTick and txDone and compares per bit.
module tb_uart_tx_param;

  localparam int OS = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sTick = 1'b0;
  logic       txStart = 1'b0;
  logic [7:0] din = 8'h00;
  logic [1:0] parityMode = 2'b00;
  logic       stopTwo = 1'b0;
  logic       txBreak = 1'b0;
  logic       tx, txRdTick, txBusy, txDone;

  always #5 clk = ~clk;

  uart_tx_param #(.DATA_BITS(8), .OVERSAMPLE(OS), .TICK_W(5)) dut (
    .clk(clk), .reset(reset), .sTick(sTick), .txStart(txStart), .din(din),
    .parityMode(parityMode), .stopTwo(stopTwo), .txBreak(txBreak),
    .tx(tx), .txRdTick(txRdTick), .txBusy(txBusy), .txDone(txDone)
  );

  int total = 0;
  int bad = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail(string name);
    total++;
    bad++;
    $display("FAIL %s: bound expired", name);
  endtask

  typedef struct {
    logic [11:0] bits;
    int          n;
    string       name;
  } frame_t;

  frame_t exp_q[$];

  // expected line bits, one entry per bit period; parity bit is hand-computed by the caller
  task automatic push_exp(string nm, logic [7:0] d, bit has_par, logic par, bit two);
    frame_t f;
    int n;
    f.bits = '0;
    for (int i = 0; i < 8; i++) f.bits[i+1] = d[i];
    n = 9;
    if (has_par) begin
      f.bits[n] = par;
      n++;
    end
    f.bits[n] = 1'b1;
    n++;
    if (two) begin
      f.bits[n] = 1'b1;
      n++;
    end
    f.n = n;
    f.name = nm;
    exp_q.push_back(f);
  endtask

  int tick_div = 1;
  initial begin
    int c;
    c = 0;
    forever begin
      @(posedge clk);
      #1;
      if (c >= tick_div - 1) begin
        sTick = 1'b1;
        c = 0;
      end else begin
        sTick = 1'b0;
        c++;
      end
    end
  end

  logic tq[$];
  bit   rec = 1'b0;
  int   rd_cnt = 0;
  int   done_cnt = 0;
  int   busy_clks = 0;

  task automatic check_frame();
    frame_t f;
    int errs;
    if (exp_q.size() == 0) begin
      fail("sb_unexpected_frame");
      return;
    end
    f = exp_q.pop_front();
    check({f.name, "_len"}, tq.size(), f.n * OS);
    if (tq.size() == f.n * OS) begin
      errs = 0;
      for (int k = 0; k < f.n; k++)
        for (int t = 0; t < OS; t++)
          if (tq[k*OS + t] !== f.bits[k]) errs++;
      check({f.name, "_bits"}, errs, 0);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (rec) begin
          rec = 1'b0;
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
      end else begin
        if (txRdTick) rd_cnt++;
        if (txDone) done_cnt++;
        if (txBusy) busy_clks++;
        if (rec) begin
          if (txDone) begin
            rec = 1'b0;
            check_frame();
          end else if (sTick) begin
            tq.push_back(tx);
          end
        end
        if (!rec && txRdTick) begin
          rec = 1'b1;
          tq.delete();
        end
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (txBusy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) fail("wait_idle");
    repeat (2) @(negedge clk);
  endtask

  task automatic send(logic [7:0] d, logic [1:0] pm, logic s2);
    @(posedge clk);
    #1;
    din = d;
    parityMode = pm;
    stopTwo = s2;
    txStart = 1'b1;
    @(posedge clk);
    #1;
    txStart = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, r0, d0, n, p;

    txStart = 1'b1;
    #12;
    check("rst_tx", tx, 1);
    check("rst_busy", txBusy, 0);
    check("rst_done", txDone, 0);
    check("rst_rdtick", txRdTick, 0);
    txStart = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);

    b0 = busy_clks; r0 = rd_cnt; d0 = done_cnt;
    push_exp("t1_55", 8'h55, 0, 1'b0, 0);
    send(8'h55, 2'b00, 1'b0);
    wait_idle();
    check("t1_busy_clks", busy_clks - b0, 160);
    check("t1_rdtick_cnt", rd_cnt - r0, 1);
    check("t1_done_cnt", done_cnt - d0, 1);
    check("t1_idle_tx", tx, 1);

    b0 = busy_clks;
    push_exp("t2_even07", 8'h07, 1, 1'b1, 0);
    send(8'h07, 2'b01, 1'b0);
    wait_idle();
    check("t2_busy_clks", busy_clks - b0, 176);
    push_exp("t2_odd00", 8'h00, 1, 1'b1, 0);
    send(8'h00, 2'b10, 1'b0);
    wait_idle();
    push_exp("t2_even00", 8'h00, 1, 1'b0, 0);
    send(8'h00, 2'b01, 1'b0);
    wait_idle();
    push_exp("t2_mode3", 8'h81, 0, 1'b0, 0);
    send(8'h81, 2'b11, 1'b0);
    wait_idle();

    b0 = busy_clks;
    push_exp("t3_a3", 8'hA3, 0, 1'b0, 1);
    send(8'hA3, 2'b00, 1'b1);
    wait_idle();
    check("t3_busy_clks", busy_clks - b0, 176);
    b0 = busy_clks;
    push_exp("t3_mid", 8'h3C, 0, 1'b0, 1);
    send(8'h3C, 2'b00, 1'b1);
    repeat (50) @(posedge clk);
    #1;
    stopTwo = 1'b0;
    parityMode = 2'b01;
    wait_idle();
    check("t3_mid_busy_clks", busy_clks - b0, 176);
    parityMode = 2'b00;

    r0 = rd_cnt;
    push_exp("t4_12", 8'h12, 0, 1'b0, 0);
    push_exp("t4_34", 8'h34, 0, 1'b0, 0);
    @(posedge clk);
    #1;
    din = 8'h12;
    txStart = 1'b1;
    n = 0;
    while (!txRdTick && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) fail("t4_first_rd");
    @(posedge clk);
    #1;
    din = 8'h34;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!txRdTick && n < 400);
    if (n >= 400) fail("t4_second_rd");
    check("t4_b2b_done", txDone, 1);
    @(posedge clk);
    #1;
    txStart = 1'b0;
    check("t4_start_tx", tx, 0);
    wait_idle();
    check("t4_rdtick_cnt", rd_cnt - r0, 2);

    tick_div = 3;
    repeat (4) @(posedge clk);
    push_exp("t5_55", 8'h55, 0, 1'b0, 0);
    @(posedge clk);
    #1;
    din = 8'h55;
    txStart = 1'b1;
    @(posedge clk);
    #1;
    txStart = 1'b0;
    din = 8'hFF;
    n = 0;
    while (tx == 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    p = 0;
    while (tx == 1'b1 && p < 200) begin
      @(negedge clk);
      p++;
    end
    check("t5_bit_period", p, 48);
    wait_idle();
    tick_div = 1;
    repeat (4) @(posedge clk);

    push_exp("t6_ff_aborted", 8'hFF, 0, 1'b0, 0);
    send(8'hFF, 2'b00, 1'b0);
    repeat (40) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("t6_async_tx", tx, 1);
    check("t6_async_busy", txBusy, 0);
    txBreak = 1'b1;
    txStart = 1'b1;
    din = 8'h3C;
    @(negedge clk);
    check("t6_sb_flush", exp_q.size(), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    r0 = rd_cnt;
    repeat (5) @(posedge clk);
    #1;
    check("t6_break_tx", tx, 0);
    check("t6_break_rdtick", txRdTick, 0);
    check("t6_break_rdcnt", rd_cnt - r0, 0);
    check("t6_break_busy", txBusy, 0);
    push_exp("t6_3c", 8'h3C, 0, 1'b0, 0);
    txBreak = 1'b0;
    #1;
    check("t6_release_rdtick", txRdTick, 1);
    @(posedge clk);
    #1;
    txStart = 1'b0;
    check("t6_start_busy", txBusy, 1);
    check("t6_start_tx", tx, 0);
    wait_idle();

    repeat (5) @(posedge clk);
    check("sb_drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
